// File: rtl/isqrt_arbiter.sv
// Round-robin front end that shares one fixed-latency isqrt unit between N requesters.
// Each transaction takes LAT+3 cycles, from the grant edge to the IDLE cycle that follows the ack.
module isqrt_arbiter #(
  parameter int N   = 4,
  parameter int IW  = 2,
  parameter int W   = 8,
  parameter int R   = 4,
  parameter int LAT = 10
) (
  input  logic           clk,
  input  logic           clr,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] a_flat,
  output logic [N-1:0]   ack,
  output logic [R-1:0]   result,
  output logic [IW-1:0]  result_id,
  output logic           busy,
  output logic [W-1:0]   sq_a,
  output logic           sq_start,
  input  logic [R-1:0]   sq_sqrt
);

  localparam int CW = $clog2(LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_DONE} state_t;

  state_t        r_state;
  logic [IW-1:0] r_last;
  logic [IW-1:0] r_gid;
  logic [CW-1:0] r_cnt;

  logic          w_found;
  logic [IW-1:0] w_grant_id;
  logic [IW-1:0] w_idx;

  // Search starts one past the last winner; IW-bit wrap gives the modulo-N step.
  always_comb begin
    w_found    = 1'b0;
    w_grant_id = r_last;
    w_idx      = r_last;
    for (int k = 1; k <= N; k++) begin
      w_idx = r_last + IW'(k);
      if (!w_found && req[w_idx]) begin
        w_found    = 1'b1;
        w_grant_id = w_idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state   <= S_IDLE;
      r_last    <= IW'(N - 1);
      r_gid     <= '0;
      r_cnt     <= '0;
      ack       <= '0;
      result    <= '0;
      result_id <= '0;
      busy      <= 1'b0;
      sq_a      <= '0;
      sq_start  <= 1'b0;
    end else begin
      sq_start <= 1'b0;
      ack      <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            sq_a     <= a_flat[w_grant_id*W +: W];
            r_gid    <= w_grant_id;
            sq_start <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= CW'(LAT);
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // Capture on the last of LAT wait cycles so ack lands in DONE.
          if (r_cnt == CW'(1)) begin
            result    <= sq_sqrt;
            result_id <= r_gid;
            ack       <= {{(N-1){1'b0}}, 1'b1} << r_gid;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_last  <= r_gid;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isqrt_arbiter.sv
// Directed bench for isqrt_arbiter with a behavioural fixed-latency isqrt model on sq_*.
module tb_isqrt_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int W   = 8;
  localparam int R   = 4;
  localparam int LAT = 10;

  logic           clk = 1'b0;
  logic           clr = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] a_flat = '0;
  logic [N-1:0]   ack;
  logic [R-1:0]   result;
  logic [IW-1:0]  result_id;
  logic           busy;
  logic [W-1:0]   sq_a;
  logic           sq_start;
  logic [R-1:0]   sq_sqrt;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;

  isqrt_arbiter #(.N(N), .IW(IW), .W(W), .R(R), .LAT(LAT)) dut (
    .clk(clk), .clr(clr), .req(req), .a_flat(a_flat), .ack(ack),
    .result(result), .result_id(result_id), .busy(busy),
    .sq_a(sq_a), .sq_start(sq_start), .sq_sqrt(sq_sqrt)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic do_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
  endtask

  function automatic logic [R-1:0] isqrt_ref(input logic [W-1:0] a);
    logic [R-1:0] r;
    r = '0;
    for (int k = 0; k < (1 << R); k++)
      if (k * k <= int'(a)) r = R'(k);
    return r;
  endfunction

  // isqrt model: operand latched at the start pulse, root valid LAT cycles later,
  // bit-inverted (always wrong) while still computing.
  logic [W-1:0] m_a   = '0;
  int           m_cnt = 0;
  always @(posedge clk) begin
    if (sq_start) begin
      m_a   <= sq_a;
      m_cnt <= LAT - 1;
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
    end
  end
  assign sq_sqrt = (m_cnt == 0) ? isqrt_ref(m_a) : ~isqrt_ref(m_a);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // ack protocol monitor
  logic [N-1:0] prev_ack = '0;
  always @(negedge clk) begin
    if (sq_start) n_start <= n_start + 1;
    if (ack != '0) begin
      check("ack_onehot", 32'($onehot(ack)), 1);
      check("ack_single_cycle", 32'(prev_ack == '0), 1);
    end
    prev_ack <= ack;
  end

  // driver tasks
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic set_op(input int id, input logic [W-1:0] val);
    a_flat[id*W +: W] = val;
  endtask

  task automatic wait_ack(output int cyc);
    cyc = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      cyc++;
      if (ack != '0) break;
    end
    if (ack == '0) check("ack_timeout", 0, 1);
  endtask

  task automatic run_one(input int id, input logic [W-1:0] val, input int exp, input string tag);
    int cyc;
    step();
    set_op(id, val);
    req = N'(1 << id);
    wait_ack(cyc);
    req = '0;
    check({tag, "_lat"}, cyc, LAT + 2);
    check({tag, "_ack"}, ack, 1 << id);
    check({tag, "_id"}, result_id, id);
    check({tag, "_res"}, result, exp);
    check({tag, "_model"}, result, isqrt_ref(val));
  endtask

  int rr_id[5]  = '{0, 1, 2, 3, 0};
  int rr_res[5] = '{0, 1, 15, 10, 0};

  initial begin
    int cyc;
    int s;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;

    // reset state
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    check("rst_result_id", result_id, 0);
    check("rst_sq_a", sq_a, 0);
    check("rst_sq_start", sq_start, 0);

    // single request, a=144
    s = n_start;
    set_op(0, 144);
    req = 4'b0001;
    step();
    check("single_sq_start_c1", sq_start, 1);
    check("single_busy_c1", busy, 1);
    check("single_sq_a", sq_a, 144);
    req = 4'b0000;
    step();
    check("single_sq_start_c2", sq_start, 0);
    wait_ack(cyc);
    check("single_ack_cycle", cyc + 2, LAT + 2);
    check("single_ack", ack, 4'b0001);
    check("single_result", result, 12);
    check("single_id", result_id, 0);
    step();
    check("single_busy_idle", busy, 0);
    repeat (LAT + 4) step();
    check("single_one_start", n_start - s, 1);
    check("single_result_held", result, 12);

    // all requesting continuously
    do_reset();
    set_op(0, 0); set_op(1, 1); set_op(2, 255); set_op(3, 100);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(cyc);
      if (i == 4) req = '0;
      check("rr_id", result_id, rr_id[i]);
      check("rr_res", result, rr_res[i]);
      check("rr_gap", cyc, (i == 0) ? LAT + 2 : LAT + 3);
    end

    // pointer wrap: after serving 2, req=0110 goes 1 then 2
    step();
    set_op(2, 64);
    req = 4'b0100;
    wait_ack(cyc);
    check("wrap_first_id", result_id, 2);
    set_op(1, 16); set_op(2, 9);
    req = 4'b0110;
    wait_ack(cyc);
    check("wrap_second_id", result_id, 1);
    check("wrap_second_res", result, 4);
    check("wrap_second_gap", cyc, LAT + 3);
    wait_ack(cyc);
    req = '0;
    check("wrap_third_id", result_id, 2);
    check("wrap_third_res", result, 3);
    check("wrap_third_gap", cyc, LAT + 3);

    // operand stability and req drop after grant
    step();
    set_op(1, 49);
    req = 4'b0010;
    step();
    check("stab_sq_a_c1", sq_a, 49);
    set_op(1, 81);
    req = '0;
    cyc = 0;
    for (int k = 0; k < 50; k++) begin
      step();
      cyc++;
      check("stab_sq_a", sq_a, 49);
      if (ack != '0) break;
    end
    check("stab_ack", ack, 4'b0010);
    check("stab_ack_cycle", cyc + 1, LAT + 2);
    check("stab_result", result, 7);
    check("stab_id", result_id, 1);

    // mid-operation reset in the 3rd WAIT cycle
    step();
    set_op(2, 200);
    req = 4'b0100;
    repeat (4) step();
    check("midrst_busy_before", busy, 1);
    clr = 1'b1;
    s = n_start;
    step();
    check("midrst_ack", ack, 0);
    check("midrst_busy", busy, 0);
    check("midrst_sq_start", sq_start, 0);
    check("midrst_result", result, 0);
    check("midrst_sq_a", sq_a, 0);
    clr = 1'b0;
    set_op(0, 36);
    req = 4'b0101;
    wait_ack(cyc);
    req = '0;
    check("midrst_first_id", result_id, 0);
    check("midrst_first_res", result, 6);
    check("midrst_lat", cyc, LAT + 2);
    check("midrst_starts", n_start - s, 1);

    // boundaries against the model
    run_one(3, 0, 0, "bnd0");
    run_one(3, 255, 15, "bnd255");
    run_one(3, 225, 15, "bnd225");
    run_one(2, 224, 14, "bnd224");

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
